// File: rtl/vid_timing_gen.sv
// Video timing and test-pattern generator: blanking-first h/v timing, programmable
// sync polarity, five selectable patterns, all outputs registered one cycle after the counters.
module vid_timing_gen #(
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int H_ACTIVE  = 640,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int V_ACTIVE  = 480,
    parameter int HSYNC_POL = 1,
    parameter int VSYNC_POL = 1,
    parameter int COMP_W    = 12,
    parameter int CNT_W     = 12,
    parameter int CHK_LOG2  = 5
) (
    input  logic                vid_clk,
    input  logic                vid_reset_n,
    input  logic                enable,
    input  logic [2:0]          pattern_sel,
    output logic                de,
    output logic                hsync,
    output logic                vsync,
    output logic [3*COMP_W-1:0] d,
    output logic                frame_start,
    output logic [CNT_W-1:0]    col,
    output logic [CNT_W-1:0]    line
);

    localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
    localparam int H_TOTAL = H_BLANK + H_ACTIVE;
    localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;
    localparam int V_TOTAL = V_BLANK + V_ACTIVE;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_BLANK_C  = CNT_W'(H_BLANK);
    localparam logic [CNT_W-1:0] H_LAST_C   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_BLANK_C  = CNT_W'(V_BLANK);
    localparam logic [CNT_W-1:0] V_LAST_C   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] OFS_LAST_C = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HS_BEG_C   = CNT_W'(H_FRONT);
    localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG_C   = CNT_W'(V_FRONT);
    localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(V_FRONT + V_SYNC);
    localparam logic [CNT_W-1:0] BAR_LAST_C = CNT_W'(BAR_W - 1);
    localparam logic             HPOL       = (HSYNC_POL != 0);
    localparam logic             VPOL       = (VSYNC_POL != 0);
    localparam logic [COMP_W-1:0] ONES      = {COMP_W{1'b1}};

    function automatic logic [COMP_W-1:0] shl3(input logic [CNT_W-1:0] v);
        return COMP_W'({v, 3'b000});
    endfunction

    logic [CNT_W-1:0] col_q, col_d, line_q, line_d, ofs_q, ofs_d;
    logic [CNT_W-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]       bar_idx_q, bar_idx_d, pat_q, pat_d, pat_eff;
    logic             origin, active, in_hs, in_vs;
    logic [CNT_W-1:0] x, y;
    logic [3*COMP_W-1:0] pix;

    logic                de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
    logic [3*COMP_W-1:0] pix_q, pix_d;
    logic [CNT_W-1:0]    col_out_q, col_out_d, line_out_q, line_out_d;

    assign origin = (col_q == '0) && (line_q == '0);
    assign active = (line_q >= V_BLANK_C) && (col_q >= H_BLANK_C);
    assign in_hs  = (col_q >= HS_BEG_C) && (col_q < HS_END_C);
    assign in_vs  = (line_q >= VS_BEG_C) && (line_q < VS_END_C);
    assign x      = col_q - H_BLANK_C;
    assign y      = line_q - V_BLANK_C;

    // Counter next-state; the bar counter only runs between the first and last active column
    always_comb begin
        col_d     = col_q;
        line_d    = line_q;
        ofs_d     = ofs_q;
        pat_d     = pat_q;
        bar_cnt_d = '0;
        bar_idx_d = '0;
        if (!enable) begin
            col_d  = '0;
            line_d = '0;
        end else begin
            if (origin) pat_d = pattern_sel;
            if (col_q == H_LAST_C) begin
                col_d = '0;
                if (line_q == V_LAST_C) begin
                    line_d = '0;
                    ofs_d  = (ofs_q == OFS_LAST_C) ? '0 : ofs_q + ONE_C;
                end else begin
                    line_d = line_q + ONE_C;
                end
            end else begin
                col_d = col_q + ONE_C;
            end
            if ((col_q >= H_BLANK_C) && (col_q != H_LAST_C)) begin
                if (bar_cnt_q == BAR_LAST_C) begin
                    bar_cnt_d = '0;
                    bar_idx_d = bar_idx_q + 3'd1;
                end else begin
                    bar_cnt_d = bar_cnt_q + ONE_C;
                    bar_idx_d = bar_idx_q;
                end
            end
        end
    end

    // At frame origin the freshly sampled selection applies to the origin cycle too
    assign pat_eff = origin ? pattern_sel : pat_q;

    always_comb begin
        pix = '0;
        case (pat_eff)
            3'd1: pix = {{COMP_W{~bar_idx_q[1]}}, {COMP_W{~bar_idx_q[2]}}, {COMP_W{~bar_idx_q[0]}}};
            3'd2: pix = {shl3(y), ONES, shl3(x)};
            3'd3: pix = (y < ofs_q) ? {ONES, shl3(y), shl3(x)} : {shl3(y), ONES, shl3(x)};
            3'd4: pix = (x[CHK_LOG2] ^ y[CHK_LOG2]) ? {3{ONES}} : '0;
            default: pix = '0;
        endcase
    end

    always_comb begin
        de_d       = 1'b0;
        hs_d       = ~HPOL;
        vs_d       = ~VPOL;
        pix_d      = '0;
        fs_d       = 1'b0;
        col_out_d  = '0;
        line_out_d = '0;
        if (enable) begin
            de_d       = active;
            hs_d       = in_hs ? HPOL : ~HPOL;
            vs_d       = in_vs ? VPOL : ~VPOL;
            pix_d      = active ? pix : '0;
            fs_d       = origin;
            col_out_d  = col_q;
            line_out_d = line_q;
        end
    end

    always_ff @(posedge vid_clk or negedge vid_reset_n) begin
        if (!vid_reset_n) begin
            col_q      <= '0;
            line_q     <= '0;
            ofs_q      <= '0;
            pat_q      <= '0;
            bar_cnt_q  <= '0;
            bar_idx_q  <= '0;
            de_q       <= 1'b0;
            hs_q       <= ~HPOL;
            vs_q       <= ~VPOL;
            pix_q      <= '0;
            fs_q       <= 1'b0;
            col_out_q  <= '0;
            line_out_q <= '0;
        end else begin
            col_q      <= col_d;
            line_q     <= line_d;
            ofs_q      <= ofs_d;
            pat_q      <= pat_d;
            bar_cnt_q  <= bar_cnt_d;
            bar_idx_q  <= bar_idx_d;
            de_q       <= de_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            pix_q      <= pix_d;
            fs_q       <= fs_d;
            col_out_q  <= col_out_d;
            line_out_q <= line_out_d;
        end
    end

    assign de          = de_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign d           = pix_q;
    assign frame_start = fs_q;
    assign col         = col_out_q;
    assign line        = line_out_q;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen on a 24x7 frame: a frame-position reference model checks every
// cycle of two instances (positive and negative sync polarity) under directed and random stimulus.
module tb_vid_timing_gen;

    localparam int HF = 2, HS = 3, HB = 3, HA = 16;
    localparam int VF = 1, VS = 1, VB = 1, VA = 4;
    localparam int HBL = HF + HS + HB, HT = HBL + HA;
    localparam int VBL = VF + VS + VB, VT = VBL + VA;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n, en;
    logic [2:0]  psel;

    logic        de_p, hs_p, vs_p, fs_p, de_n, hs_n, vs_n, fs_n;
    logic [35:0] d_p, d_n;
    logic [11:0] col_p, line_p, col_n, line_n;

    vid_timing_gen #(.H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
                     .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA),
                     .HSYNC_POL(1), .VSYNC_POL(1), .COMP_W(12), .CNT_W(12), .CHK_LOG2(1))
    dut (.vid_clk(clk), .vid_reset_n(rst_n), .enable(en), .pattern_sel(psel),
         .de(de_p), .hsync(hs_p), .vsync(vs_p), .d(d_p), .frame_start(fs_p),
         .col(col_p), .line(line_p));

    vid_timing_gen #(.H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
                     .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA),
                     .HSYNC_POL(0), .VSYNC_POL(0), .COMP_W(12), .CNT_W(12), .CHK_LOG2(1))
    dut_n (.vid_clk(clk), .vid_reset_n(rst_n), .enable(en), .pattern_sel(psel),
           .de(de_n), .hsync(hs_n), .vsync(vs_n), .d(d_n), .frame_start(fs_n),
           .col(col_n), .line(line_n));

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int t = 0, ofs_m = 0, pat_m = 0;
    int de_cnt = 0, fs_cnt = 0, hs_cnt = 0, vs_cnt = 0;
    logic [35:0] bars [8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    function automatic logic [35:0] exp_pix(input int p, input int x, input int y, input int ofs);
        logic [11:0] xs, ys;
        xs = 12'(x * 8);
        ys = 12'(y * 8);
        case (p)
            1: return bars[x / (HA / 8)];
            2: return {ys, 12'hFFF, xs};
            3: return (y < ofs) ? {12'hFFF, ys, xs} : {ys, 12'hFFF, xs};
            4: return ((((x / 2) ^ (y / 2)) % 2) == 1) ? 36'hFFFFFFFFF : 36'h0;
            default: return 36'h0;
        endcase
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_de"}, 64'(de_p), 64'(0));
        chk({tag, "_hs"}, 64'(hs_p), 64'(0));
        chk({tag, "_vs"}, 64'(vs_p), 64'(0));
        chk({tag, "_d"}, 64'(d_p), 64'(0));
        chk({tag, "_fs"}, 64'(fs_p), 64'(0));
        chk({tag, "_col"}, 64'(col_p), 64'(0));
        chk({tag, "_line"}, 64'(line_p), 64'(0));
        chk({tag, "_hs_n"}, 64'(hs_n), 64'(1));
        chk({tag, "_vs_n"}, 64'(vs_n), 64'(1));
    endtask

    // Expected outputs follow from the cycle position inside the frame
    task automatic check_outputs();
        logic e_de, e_hs, e_vs, e_fs;
        logic [35:0] e_d;
        int pos, c, l;
        e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_fs = 1'b0; e_d = '0; c = 0; l = 0;
        if (!rst_n || !en) begin
            t = 0;
        end else begin
            pos = t % FRAME;
            c = pos % HT;
            l = pos / HT;
            if (pos == 0) pat_m = int'(psel);
            e_de = (l >= VBL) && (c >= HBL);
            e_hs = (c >= HF) && (c < HF + HS);
            e_vs = (l >= VF) && (l < VF + VS);
            e_fs = (pos == 0);
            e_d  = e_de ? exp_pix(pat_m, c - HBL, l - VBL, ofs_m) : 36'h0;
            t++;
            if (pos == FRAME - 1) ofs_m = (ofs_m + 1) % VA;
        end
        chk("de", 64'(de_p), 64'(e_de));
        chk("hsync", 64'(hs_p), 64'(e_hs));
        chk("vsync", 64'(vs_p), 64'(e_vs));
        chk("d", 64'(d_p), 64'(e_d));
        chk("frame_start", 64'(fs_p), 64'(e_fs));
        chk("col", 64'(col_p), 64'(c));
        chk("line", 64'(line_p), 64'(l));
        chk("hsync_n", 64'(hs_n), 64'(!e_hs));
        chk("vsync_n", 64'(vs_n), 64'(!e_vs));
        chk("de_n", 64'(de_n), 64'(e_de));
        chk("d_n", 64'(d_n), 64'(e_d));
        if (de_p) de_cnt++;
        if (fs_p) fs_cnt++;
        if (hs_p) hs_cnt++;
        if (vs_p) vs_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    // Asynchronous reset pulse launched between clock edges, held for two edges
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_reset(tag);
        ofs_m = 0;
        pat_m = 0;
        t = 0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        bars = '{36'hFFFFFFFFF, 36'hFFFFFF000, 36'h000FFFFFF, 36'h000FFF000,
                 36'hFFF000FFF, 36'hFFF000000, 36'h000000FFF, 36'h000000000};
        rst_n = 1'b1;
        en    = 1'b0;
        psel  = 3'd0;

        do_reset("reset");
        en = 1'b1;

        // Black pattern for two frames with aggregate pulse counts
        de_cnt = 0; fs_cnt = 0; hs_cnt = 0; vs_cnt = 0;
        for (int i = 0; i < 2 * FRAME; i++) step();
        chk("de_count", 64'(de_cnt), 64'(128));
        chk("fs_count", 64'(fs_cnt), 64'(2));
        chk("hs_count", 64'(hs_cnt), 64'(42));
        chk("vs_count", 64'(vs_cnt), 64'(48));

        // Colour bars
        psel = 3'd1;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (i == VBL * HT + HBL + 2) chk("bar1_yellow", 64'(d_p), 64'(36'hFFFFFF000));
        end

        // Scrolling split over five frames from a fresh offset
        do_reset("reset2");
        psel = 3'd3;
        for (int i = 0; i < 5 * FRAME; i++) begin
            step();
            if (i == VBL * HT + HBL)               chk("split_f0_R", 64'(d_p[35:24]), 64'(0));
            if (i == 2 * FRAME + VBL * HT + HBL)   chk("split_f2_R", 64'(d_p[35:24]), 64'(12'hFFF));
            if (i == 3 * FRAME + (VBL + 2) * HT + HBL) chk("split_f3_R", 64'(d_p[35:24]), 64'(12'hFFF));
            if (i == 4 * FRAME + VBL * HT + HBL)   chk("split_f4_G", 64'(d_p[23:12]), 64'(12'hFFF));
        end

        // Mid-frame pattern change takes effect only at the next frame
        psel = 3'd0;
        for (int i = 0; i < 50; i++) step();
        psel = 3'd4;
        for (int i = 50; i < FRAME; i++) step();
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (i == VBL * HT + HBL)     chk("chk_x0y0", 64'(d_p), 64'(0));
            if (i == VBL * HT + HBL + 2) chk("chk_x2y0", 64'(d_p), 64'(36'hFFFFFFFFF));
        end

        // Random pattern changes, enable drops and asynchronous resets
        for (int i = 0; i < 1500; i++) begin
            step();
            if ($urandom_range(29, 0) == 0) psel = 3'($urandom_range(7, 0));
            if ($urandom_range(149, 0) == 0) begin
                en = 1'b0;
                repeat ($urandom_range(4, 1)) step();
                en = 1'b1;
            end
            if ($urandom_range(499, 0) == 0) do_reset("rnd_reset");
        end

        // Enable dropped mid-line, then reset asserted mid-line
        psel = 3'd2;
        for (int i = 0; i < 40; i++) step();
        en = 1'b0;
        step();
        en = 1'b1;
        step();
        chk("reen_fs", 64'(fs_p), 64'(1));
        for (int i = 0; i < 30; i++) step();
        do_reset("mid_reset");
        step();
        chk("rel_fs", 64'(fs_p), 64'(1));
        chk("rel_col", 64'(col_p), 64'(0));
        for (int i = 0; i < FRAME; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
